mdu_issue_ctrl: RTL
===================

Name: mdu_issue_ctrl

Overview:
- D-stage issue/hazard controller for the E-stage multiply/divide unit; it is the requesting side of the MDU start/busy interface.
- Mirrors which MDU op occupies E and its remaining latency, then stalls D-stage MDU-class instructions until the unit can take them.
- Cross-checks its latency mirror against the MDU's own busy flag.
- Counts MDU-induced stall cycles for performance debug.

Parameters:
- MULT_LAT, 5: busy cycles after a mult/multu leaves E.
- DIV_LAT, 10: busy cycles after a div/divu leaves E.
- CNT_W, 5: latency counter width; must hold max(MULT_LAT, DIV_LAT).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- D_MDUType  in  5  MDU op of the D-stage instruction; MDUType_* encodings from const.v; nop = none.
- other_stall  in  1  stall from other hazard sources (load-use etc.).
- E_clr  in  1  forces the E slot to nop next edge (flush).
- mdu_busy  in  1  busy flag from the E-stage MDU; cross-check only.
- stat_clr  in  1  synchronous clear of stall_cnt.
- MDU_stall  out  1  D-stage stall request due to MDU hazard.
- E_MDUType  out  5  registered op now in E; drives the MDU.
- E_start  out  1  E_MDUType is mult/multu/div/divu.
- mirror_busy  out  1  internal latency counter > 0.
- err  out  1  sticky mismatch flag.
- stall_cnt  out  32  saturating count of MDU_stall cycles.

Behaviour:
- Reset (reset=0, async): E_MDUType=nop, cnt=0, err=0, stall_cnt=0; hence MDU_stall=0, E_start=0, mirror_busy=0.
- D_isMD = D_MDUType ∈ {mult, multu, div, divu, mfhi, mflo, mthi, mtlo}.
- MDU_stall = D_isMD & (E_start | cnt!=0). Combinational; no dependency on mdu_busy.
- E slot, per edge, in priority order:
  - E_clr → nop.
  - MDU_stall | other_stall → nop (bubble).
  - Otherwise → D_MDUType.
- Counter, per edge:
  - E_start & cnt==0 → cnt ← MULT_LAT for mult/multu, DIV_LAT for div/divu.
  - Else if cnt!=0 → cnt ← cnt−1.
  - E_start with cnt!=0 is illegal: no reload, cnt decrements, err ← 1.
- Timing: mult issued from D at cycle t → E at t+1 (E_start=1) → cnt=MULT_LAT..1 over t+2..t+1+MULT_LAT.
  - A D-stage MDU-class op arriving at t+1 stalls through t+1+MULT_LAT, then issues at t+2+MULT_LAT: 1+MULT_LAT stall cycles.
  - Same pattern for div with DIV_LAT.
- E_clr does not cancel a running counter; the MDU has already committed to the op.
- E_clr on the same edge an op would enter E: the op is dropped, cnt is not loaded for it, and D advances (the pipeline's flush decides D).
- Non-start MDU ops in E (mfhi/mflo/mthi/mtlo) do not touch cnt and take 1 cycle.
- Cross-check, every edge with reset=1: (cnt!=0) != mdu_busy → err ← 1. err clears only on reset.
- stall_cnt:
  - Increments each cycle MDU_stall=1, saturating at 0xFFFFFFFF.
  - stat_clr has priority and sets it to 0.
  - Counts while other_stall is also asserted.
- Simultaneous MDU_stall and other_stall: a single bubble enters E; stall_cnt still increments.
- Reset asserted mid-operation: immediate async clear of all state; on release, the first edge samples inputs normally.

Test Plan:
- Reset: hold reset=0 with D_MDUType=mult → MDU_stall=0, E_MDUType=nop, stall_cnt=0; release → mult enters E next edge, E_start=1.
- mult then mflo back-to-back:
  - MDU_stall=1 for exactly 6 cycles; mflo enters E on the 7th edge after mult's D cycle.
  - mirror_busy high 5 cycles; stall_cnt=6.
- div then mthi → 11 stall cycles, cnt counts 10..1. An add (nop type) in D during this window → MDU_stall=0.
- E_clr asserted the cycle mult would enter E → E_MDUType=nop, E_start=0, cnt stays 0, no stall for a following mfhi.
- Cross-check: mdu_busy model held low while mirror counts → err=1 after the first edge with mismatch; err stays 1 until reset=0.
- Saturation and clear:
  - Preload-equivalent long stall run → stall_cnt holds 0xFFFFFFFF.
  - stat_clr together with MDU_stall=1 → stall_cnt=0 next edge.

Source files
------------

// File: rtl/mdu_issue_if.sv
// -----------------------------------------------------------------------------
// mdu_issue_if
// Start/busy link between the D-stage issue controller and the E-stage
// multiply/divide unit.
//   E_MDUType : op currently in E; tells the MDU what to execute
//   E_start   : E_MDUType is mult/multu/div/divu (the MDU starts this cycle)
//   mdu_busy  : the MDU's own busy flag, returned to the controller
// The master is the issue controller. The slave is the MDU.
// -----------------------------------------------------------------------------
interface mdu_issue_if;
  logic [4:0] E_MDUType;
  logic       E_start;
  logic       mdu_busy;

  modport master (
    output E_MDUType,
    output E_start,
    input  mdu_busy
  );

  modport slave (
    input  E_MDUType,
    input  E_start,
    output mdu_busy
  );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_issue_ctrl
// D-stage issue/hazard controller for the E-stage multiply/divide unit.
// It keeps its own copy of the op in E and of the MDU's remaining latency.
// It stalls D-stage MDU-class instructions until the unit can accept them.
// It cross-checks the latency copy against the MDU busy flag.
// It also counts the stall cycles that the MDU causes.
//
// Ports
//   clk          system clock
//   reset        asynchronous active-low reset
//   D_MDUType    MDU op of the D-stage instruction (nop = none)
//   other_stall  stall from the other hazard sources
//   E_clr        flush: E slot becomes nop on the next edge
//   stat_clr     synchronous clear of stall_cnt
//   mdu          master side of the MDU start/busy link
//                (E_MDUType, E_start out; mdu_busy in)
//   MDU_stall    D-stage stall request caused by an MDU hazard
//   mirror_busy  internal latency counter is non-zero
//   err          sticky flag for a mirror/MDU mismatch or an illegal start
//   stall_cnt    saturating count of MDU_stall cycles
// -----------------------------------------------------------------------------
module mdu_issue_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_MDUType,
  input  logic        other_stall,
  input  logic        E_clr,
  input  logic        stat_clr,
  mdu_issue_if.master mdu,
  output logic        MDU_stall,
  output logic        mirror_busy,
  output logic        err,
  output logic [31:0] stall_cnt
);

  // MDUType encodings, shared with the rest of the pipeline
  localparam logic [4:0] MDU_NOP   = 5'd0;
  localparam logic [4:0] MDU_MULT  = 5'd1;
  localparam logic [4:0] MDU_MULTU = 5'd2;
  localparam logic [4:0] MDU_DIV   = 5'd3;
  localparam logic [4:0] MDU_DIVU  = 5'd4;
  localparam logic [4:0] MDU_MFHI  = 5'd5;
  localparam logic [4:0] MDU_MFLO  = 5'd6;
  localparam logic [4:0] MDU_MTHI  = 5'd7;
  localparam logic [4:0] MDU_MTLO  = 5'd8;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [31:0]      STAT_MAX = 32'hFFFF_FFFF;

  // The op needs the hazard check (any op that uses the HI/LO unit)
  function automatic logic is_md(input logic [4:0] t);
    case (t)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU,
      MDU_MFHI, MDU_MFLO, MDU_MTHI, MDU_MTLO: is_md = 1'b1;
      default:                                is_md = 1'b0;
    endcase
  endfunction

  // The op starts a multi-cycle MDU operation
  function automatic logic is_start(input logic [4:0] t);
    case (t)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: is_start = 1'b1;
      default:                                is_start = 1'b0;
    endcase
  endfunction

  // Busy cycles that follow a starting op after it leaves E
  function automatic logic [CNT_W-1:0] start_lat(input logic [4:0] t);
    case (t)
      MDU_MULT, MDU_MULTU: start_lat = CNT_W'(MULT_LAT);
      MDU_DIV,  MDU_DIVU:  start_lat = CNT_W'(DIV_LAT);
      default:             start_lat = CNT_ZERO;
    endcase
  endfunction

  logic [4:0]       e_type_r;
  logic             e_start_r;
  logic [CNT_W-1:0] cnt_r;
  logic             mirror_busy_r;
  logic             err_r;
  logic [31:0]      stall_cnt_r;

  logic [4:0]       e_type_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             err_nxt_s;
  logic [31:0]      stall_cnt_nxt_s;
  logic             mdu_stall_s;

  // Hazard: an MDU-class op in D must wait while an op starts in E or the unit is still counting
  always_comb begin
    mdu_stall_s = is_md(D_MDUType) & (e_start_r | (cnt_r != CNT_ZERO));
  end

  // Next E slot (flush first, then bubble, then advance), latency mirror, error and statistics
  always_comb begin
    e_type_nxt_s    = MDU_NOP;
    cnt_nxt_s       = cnt_r;
    err_nxt_s       = err_r;
    stall_cnt_nxt_s = stall_cnt_r;

    if (E_clr) begin
      e_type_nxt_s = MDU_NOP;
    end else if (mdu_stall_s | other_stall) begin
      e_type_nxt_s = MDU_NOP;
    end else begin
      e_type_nxt_s = D_MDUType;
    end

    // A start while the mirror is still counting is illegal. The counter keeps counting down and does not reload.
    if (e_start_r && (cnt_r == CNT_ZERO)) begin
      cnt_nxt_s = start_lat(e_type_r);
    end else if (cnt_r != CNT_ZERO) begin
      cnt_nxt_s = cnt_r - CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end

    if ((e_start_r && (cnt_r != CNT_ZERO)) || ((cnt_r != CNT_ZERO) != mdu.mdu_busy)) begin
      err_nxt_s = 1'b1;
    end else begin
      err_nxt_s = err_r;
    end

    if (stat_clr) begin
      stall_cnt_nxt_s = 32'd0;
    end else if (mdu_stall_s && (stall_cnt_r != STAT_MAX)) begin
      stall_cnt_nxt_s = stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_nxt_s = stall_cnt_r;
    end
  end

  // State registers; the start/busy flags are registered from next-state so they stay glitch-free
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_type_r      <= MDU_NOP;
      e_start_r     <= 1'b0;
      cnt_r         <= CNT_ZERO;
      mirror_busy_r <= 1'b0;
      err_r         <= 1'b0;
      stall_cnt_r   <= 32'd0;
    end else begin
      e_type_r      <= e_type_nxt_s;
      e_start_r     <= is_start(e_type_nxt_s);
      cnt_r         <= cnt_nxt_s;
      mirror_busy_r <= (cnt_nxt_s != CNT_ZERO);
      err_r         <= err_nxt_s;
      stall_cnt_r   <= stall_cnt_nxt_s;
    end
  end

  assign mdu.E_MDUType = e_type_r;
  assign mdu.E_start   = e_start_r;
  assign MDU_stall     = mdu_stall_s;
  assign mirror_busy   = mirror_busy_r;
  assign err           = err_r;
  assign stall_cnt     = stall_cnt_r;

endmodule
